regfile_wb: RTL and testbench

Architectural register file at the end of the writeback stage.
- Consumes the final writeback destination and data after overflow/`jal` redirection: 5-bit register index and 32-bit value.
- Provides two combinational read ports to decode.
- Tracks overflow exceptions written to `$rstatus` (r30) through a pending-exception handshake and a saturating event counter.

---
 rtl/regfile_wb_if.sv | 29 ++
 rtl/regfile_wb.sv | 92 +++++++++
 tb/tb_regfile_wb.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Writeback/decode bus for the architectural register file.
// Carries the write port, both read ports and the overflow-exception handshake.
interface regfile_wb_if #(
    parameter int CNT_W = 8
);
    logic             ctrl_writeEnable;
    logic [4:0]       ctrl_writeReg;
    logic [31:0]      data_writeReg;
    logic [4:0]       ctrl_readRegA;
    logic [4:0]       ctrl_readRegB;
    logic [31:0]      data_readRegA;
    logic [31:0]      data_readRegB;
    logic             exc_valid;
    logic [1:0]       exc_code;
    logic             exc_ack;
    logic [CNT_W-1:0] exc_count;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_readRegA, ctrl_readRegB, exc_ack,
        input  data_readRegA, data_readRegB, exc_valid, exc_code, exc_count
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_readRegA, ctrl_readRegB, exc_ack,
        output data_readRegA, data_readRegB, exc_valid, exc_code, exc_count
    );
endinterface

// File: rtl/regfile_wb.sv
// Architectural register file with overflow tracking on $rstatus.
// Optional write-through bypass on the read ports when REGFILE_BYPASS_EN is defined.
module regfile_wb #(
    parameter int DEPTH      = 32,
    parameter int STATUS_REG = 30,
    parameter int CNT_W      = 8
) (
    input  logic         clock,
    input  logic         ctrl_reset_n,
    regfile_wb_if.slave  bus
);
    localparam logic [4:0] STATUS_IDX = 5'(STATUS_REG);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } excState_t;

    logic [31:0]      r_regs [1:DEPTH-1];
    excState_t        r_state;
    excState_t        w_nextState;
    logic [1:0]       r_code;
    logic [CNT_W-1:0] r_count;

    logic        w_write;
    logic        w_event;
    logic        w_bypA;
    logic        w_bypB;
    logic [31:0] w_storedA;
    logic [31:0] w_storedB;

    // An overflow event is a real write of 1..3 into $rstatus.
    assign w_write = bus.ctrl_writeEnable && (bus.ctrl_writeReg != 5'd0);
    assign w_event = w_write && (bus.ctrl_writeReg == STATUS_IDX)
                     && (bus.data_writeReg[31:2] == 30'd0)
                     && (bus.data_writeReg[1:0] != 2'd0);

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write) begin
            r_regs[bus.ctrl_writeReg] <= bus.data_writeReg;
        end
    end

    assign w_storedA = (bus.ctrl_readRegA == 5'd0) ? 32'd0 : r_regs[bus.ctrl_readRegA];
    assign w_storedB = (bus.ctrl_readRegB == 5'd0) ? 32'd0 : r_regs[bus.ctrl_readRegB];

`ifdef REGFILE_BYPASS_EN
    // Held reset must still read as zero, so the bypass is gated by it too.
    assign w_bypA = w_write && ctrl_reset_n && (bus.ctrl_readRegA == bus.ctrl_writeReg);
    assign w_bypB = w_write && ctrl_reset_n && (bus.ctrl_readRegB == bus.ctrl_writeReg);
`else
    assign w_bypA = 1'b0;
    assign w_bypB = 1'b0;
`endif

    assign bus.data_readRegA = w_bypA ? bus.data_writeReg : w_storedA;
    assign bus.data_readRegB = w_bypB ? bus.data_writeReg : w_storedB;

    // A new event keeps the exception pending even when acked in the same cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_event) w_nextState = PENDING;
            PENDING: if (!w_event && bus.exc_ack) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state <= IDLE;
            r_code  <= 2'd0;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_event) begin
                r_code <= bus.data_writeReg[1:0];
                if (r_count != {CNT_W{1'b1}}) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign bus.exc_valid = (r_state == PENDING);
    assign bus.exc_code  = r_code;
    assign bus.exc_count = r_count;
endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed steps then random traffic,
// all checked against a plain array/counter model of the register file.
module tb_regfile_wb;
    logic clock = 1'b0;
    logic ctrl_reset_n = 1'b0;

    regfile_wb_if #(.CNT_W(8)) bus ();

    regfile_wb #(
        .DEPTH(32),
        .STATUS_REG(30),
        .CNT_W(8)
    ) dut (
        .clock(clock),
        .ctrl_reset_n(ctrl_reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mRegs [32];
    logic        mPend;
    logic [1:0]  mCode;
    int          mCount;

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
        mPend  = 1'b0;
        mCode  = 2'd0;
        mCount = 0;
    endtask

    // Applies the architectural rules for one rising edge with the current inputs.
    task automatic modelEdge();
        logic isWrite;
        logic isEvent;
        isWrite = bus.ctrl_writeEnable && (bus.ctrl_writeReg != 5'd0);
        isEvent = isWrite && (bus.ctrl_writeReg == 5'd30)
                  && (bus.data_writeReg >= 32'd1) && (bus.data_writeReg <= 32'd3);
        if (isWrite) mRegs[bus.ctrl_writeReg] = bus.data_writeReg;
        if (isEvent) begin
            mPend = 1'b1;
            mCode = bus.data_writeReg[1:0];
            if (mCount < 255) mCount++;
        end else if (mPend && bus.exc_ack) begin
            mPend = 1'b0;
        end
    endtask

    function automatic logic [31:0] expRead(input logic [4:0] idx);
        if (!ctrl_reset_n || idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 5'd0 && bus.ctrl_writeReg == idx)
            return bus.data_writeReg;
`endif
        return mRegs[idx];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkReads(input string tag);
        checkOutput({tag, "/readA"}, bus.data_readRegA, expRead(bus.ctrl_readRegA));
        checkOutput({tag, "/readB"}, bus.data_readRegB, expRead(bus.ctrl_readRegB));
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "/valid"}, {31'd0, bus.exc_valid}, {31'd0, mPend});
        checkOutput({tag, "/code"},  {30'd0, bus.exc_code},  {30'd0, mCode});
        checkOutput({tag, "/count"}, {24'd0, bus.exc_count}, 32'(mCount));
    endtask

    // Drives one cycle at the falling edge, checks reads before and after the rising edge.
    task automatic applyStimulus(input string tag, input logic we, input logic [4:0] wr,
                                 input logic [31:0] data, input logic [4:0] ra,
                                 input logic [4:0] rb, input logic ack);
        @(negedge clock);
        bus.ctrl_writeEnable = we;
        bus.ctrl_writeReg    = wr;
        bus.data_writeReg    = data;
        bus.ctrl_readRegA    = ra;
        bus.ctrl_readRegB    = rb;
        bus.exc_ack          = ack;
        #1;
        checkReads({tag, "/pre"});
        @(posedge clock);
        modelEdge();
        #1;
        checkReads({tag, "/post"});
        checkState(tag);
    endtask

    initial begin
        logic        we;
        logic [4:0]  wr;
        logic [31:0] data;
        logic [4:0]  ra;
        logic [4:0]  rb;

        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_writeReg    = 5'd0;
        bus.data_writeReg    = 32'd0;
        bus.ctrl_readRegA    = 5'd0;
        bus.ctrl_readRegB    = 5'd30;
        bus.exc_ack          = 1'b0;
        modelReset();
        #3;
        checkReads("reset");
        checkState("reset");
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        $display("[TB] reset released");

        applyStimulus("r0write", 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
        checkOutput("r0read", bus.data_readRegA, 32'd0);
        applyStimulus("r5write", 1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5, 1'b0);
        applyStimulus("r5read", 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0);
        checkOutput("r5readA", bus.data_readRegA, 32'h12345678);
        checkOutput("r5readB", bus.data_readRegB, 32'h12345678);

        applyStimulus("exc3", 1'b1, 5'd30, 32'd3, 5'd30, 5'd0, 1'b0);
        applyStimulus("exc3hold", 1'b0, 5'd0, 32'd0, 5'd30, 5'd0, 1'b0);
        checkOutput("exc3valid", {31'd0, bus.exc_valid}, 32'd1);
        checkOutput("exc3code", {30'd0, bus.exc_code}, 32'd3);
        checkOutput("exc3count", {24'd0, bus.exc_count}, 32'd1);
        checkOutput("exc3r30", bus.data_readRegA, 32'd3);
        applyStimulus("ack", 1'b0, 5'd0, 32'd0, 5'd30, 5'd0, 1'b1);
        checkOutput("ackValid", {31'd0, bus.exc_valid}, 32'd0);
        checkOutput("ackCode", {30'd0, bus.exc_code}, 32'd3);
        applyStimulus("ackIdle", 1'b0, 5'd0, 32'd0, 5'd30, 5'd30, 1'b1);

        applyStimulus("exc1", 1'b1, 5'd30, 32'd1, 5'd30, 5'd30, 1'b0);
        applyStimulus("exc2ack", 1'b1, 5'd30, 32'd2, 5'd30, 5'd30, 1'b1);
        checkOutput("simulValid", {31'd0, bus.exc_valid}, 32'd1);
        checkOutput("simulCode", {30'd0, bus.exc_code}, 32'd2);
        checkOutput("simulCount", {24'd0, bus.exc_count}, 32'd3);
        applyStimulus("write7", 1'b1, 5'd30, 32'd7, 5'd30, 5'd0, 1'b0);
        checkOutput("write7count", {24'd0, bus.exc_count}, 32'd3);
        applyStimulus("write0", 1'b1, 5'd30, 32'd0, 5'd30, 5'd0, 1'b0);

        for (int i = 0; i < 260; i++) begin
            applyStimulus("sat", 1'b1, 5'd30, 32'd1, 5'd30, 5'd1, 1'b0);
        end
        checkOutput("satCount", {24'd0, bus.exc_count}, 32'd255);
        applyStimulus("satHold", 1'b1, 5'd30, 32'd3, 5'd30, 5'd5, 1'b1);
        checkOutput("satHoldCount", {24'd0, bus.exc_count}, 32'd255);

        applyStimulus("jal", 1'b1, 5'd31, 32'h00000ABC, 5'd31, 5'd31, 1'b0);
        applyStimulus("jalRead", 1'b0, 5'd0, 32'd0, 5'd31, 5'd30, 1'b0);
        checkOutput("jalR31", bus.data_readRegA, 32'h00000ABC);
        checkOutput("jalCount", {24'd0, bus.exc_count}, 32'd255);

        // Reset asserted between edges while a write is being presented.
        @(negedge clock);
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = 5'd9;
        bus.data_writeReg    = $urandom;
        bus.ctrl_readRegA    = 5'd9;
        bus.ctrl_readRegB    = 5'd5;
        bus.exc_ack          = 1'b0;
        #2;
        ctrl_reset_n = 1'b0;
        modelReset();
        #1;
        checkReads("midReset");
        checkState("midReset");
        checkOutput("midResetR5", bus.data_readRegB, 32'd0);
        @(posedge clock);
        #1;
        checkReads("heldReset");
        checkState("heldReset");
        @(negedge clock);
        bus.ctrl_writeEnable = 1'b0;
        ctrl_reset_n = 1'b1;
        #1;
        checkReads("afterReset");
        checkOutput("lostWrite", bus.data_readRegA, 32'd0);

        for (int i = 0; i < 400; i++) begin
            we   = ($urandom_range(0, 3) != 0);
            wr   = ($urandom_range(0, 3) == 0) ? 5'd30 : 5'(($urandom));
            data = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 8)) : $urandom;
            ra   = ($urandom_range(0, 2) == 0) ? wr : 5'(($urandom));
            rb   = ($urandom_range(0, 2) == 0) ? wr : 5'(($urandom));
            applyStimulus("rand", we, wr, data, ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
